issue_alloc_ctrl: RTL and testbench
===================================

// Module: issue_alloc_ctrl
// PURPOSE
//  Issue-stage allocation scheduler for the Tomasulo core. It gates each issued instruction
//  against ROB space and reservation-station (RS) availability for its class (add/mul/branch).
//  On acceptance it hands out the ROB tail index, then tracks ROB head/tail/occupancy and
//  per-class RS occupancy. It also handles commit, RS release and mispredict flush.
//  It replaces the ad-hoc tail_p/head_p/*_count updates scattered through the issue logic.
// PARAMETERS
//  ROB_DEPTH   8   ROB entries; must be a power of 2
//  ROB_AW      3   log2(ROB_DEPTH); width of ROB indices
//  RS_PER_CLS  3   RS entries per class (add, mul, bch)
//  CNT_W       2   width of per-class RS counters; must hold RS_PER_CLS
//  FLUSH_CYC   2   cycles spent in FLUSH before issue resumes; must be >= 1
// PORTS
//  clk1          in   1       single clock; all state changes on posedge
//  rst_n         in   1       asynchronous, active-low reset
//  iss_valid     in   1       an instruction is presented for issue
//  iss_func      in   4       opcode: 0-7 add class, 8-11 mul class, 12-15 bch class
//  iss_ready     out  1       combinational: the presented instruction is accepted this cycle
//  alloc_rob_idx out  ROB_AW  ROB index given to the accepted instruction (= current tail)
//  alloc_class   out  2       class of the accepted instruction: 0 add, 1 mul, 2 bch
//  rs_release    in   3       bit0 add, bit1 mul, bit2 bch: one RS entry of that class freed
//  commit_valid  in   1       ROB head entry retires this cycle
//  flush         in   1       branch mispredict: discard all in-flight state
//  rob_head      out  ROB_AW  oldest ROB entry
//  rob_tail      out  ROB_AW  next ROB entry to allocate
//  rob_count     out  ROB_AW+1  ROB occupancy, 0..ROB_DEPTH
//  rob_full      out  1       rob_count == ROB_DEPTH
//  rob_empty     out  1       rob_count == 0
//  add_count     out  CNT_W   occupied add RS entries
//  mul_count     out  CNT_W   occupied mul RS entries
//  bch_count     out  CNT_W   occupied bch RS entries
//  stall         out  1       iss_valid & ~iss_ready
//  stall_cycles  out  16      saturating count of stall cycles
//  err_flag      out  1       sticky error: commit on an empty ROB or release on a zero counter
// BEHAVIOUR
//  Reset:
//   - All outputs and state are 0, except rob_empty=1.
//   - FSM goes to RUN.
//  FSM:
//   - RUN -> FLUSH when flush=1.
//   - FLUSH holds FLUSH_CYC cycles, then returns to RUN.
//   - flush=1 while in FLUSH restarts the FLUSH count.
//  iss_ready = (state==RUN) & ~flush & ~rob_full & (count[class(iss_func)] < RS_PER_CLS).
//   - It uses registered state only; same-cycle commit or release does not enable issue.
//  fire = iss_valid & iss_ready. On the next edge:
//   - tail <= tail+1, wrapping from ROB_DEPTH-1 to 0.
//   - rob_count and the class counter each go up by 1.
//  alloc_rob_idx = rob_tail and alloc_class = class(iss_func), both combinational.
//  Commit:
//   - commit_valid with rob_count>0: head <= head+1 (wraps), rob_count decrements.
//   - commit_valid with rob_count==0: ignored, err_flag set.
//  rs_release bit i:
//   - counter i decrements if nonzero.
//   - If counter i is zero: ignored, err_flag set.
//  Simultaneous events:
//   - fire + commit in the same cycle: rob_count unchanged, head and tail both advance.
//   - fire + release of the same class: that counter is unchanged.
//  flush has top priority. Next edge:
//   - head, tail, rob_count and all RS counters go to 0.
//   - fire, commit and release in that cycle are discarded.
//   - err_flag and stall_cycles are kept.
//  Counters: in FLUSH, commit_valid and rs_release are ignored without setting err_flag.
//  stall_cycles increments on each cycle with stall=1 and holds at 16'hFFFF.
//  Reset mid-operation: asynchronous return to the reset state, including err_flag and stall_cycles.
// TESTING
//  1. Reset -> rob_empty=1, all counts 0, iss_ready=1 for func=0 with iss_valid=1.
//  2. Issue func 0,1,2,3 back-to-back:
//     - 3 fire with alloc_rob_idx 0,1,2; the 4th stalls with add_count=3.
//     - rs_release=001 -> 4th fires the cycle after, alloc_rob_idx=3.
//  3. Issue 8 instructions mixed across classes with commits and releases:
//     - rob_full=1 at count 8, iss_ready=0.
//     - One commit -> next issue gets idx 0 (wrap), head=1.
//  4. Same cycle fire (mul) + commit + rs_release=010 -> rob_count and mul_count unchanged;
//     head and tail +1.
//  5. flush at rob_count=5 -> next edge all counts 0, head=tail=0.
//     - iss_ready=0 for 2 cycles, then 1.
//  6. commit_valid on empty ROB -> err_flag=1 and stays 1.
//     - Hold a stall 5 cycles -> stall_cycles=5.
//     - Assert rst_n=0 mid-cycle -> immediate return to reset values.

Source files
------------

// File: rtl/issue_alloc_ctrl.sv
// Issue-stage allocation scheduler: gates issue on ROB space and per-class RS
// availability, hands out ROB tail indices and tracks head/tail/occupancy.
module issue_alloc_ctrl #(
    parameter int ROB_DEPTH  = 8,
    parameter int ROB_AW     = 3,
    parameter int RS_PER_CLS = 3,
    parameter int CNT_W      = 2,
    parameter int FLUSH_CYC  = 2
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic                iss_valid,
    input  logic [3:0]          iss_func,
    output logic                iss_ready,
    output logic [ROB_AW-1:0]   alloc_rob_idx,
    output logic [1:0]          alloc_class,
    input  logic [2:0]          rs_release,
    input  logic                commit_valid,
    input  logic                flush,
    output logic [ROB_AW-1:0]   rob_head,
    output logic [ROB_AW-1:0]   rob_tail,
    output logic [ROB_AW:0]     rob_count,
    output logic                rob_full,
    output logic                rob_empty,
    output logic [CNT_W-1:0]    add_count,
    output logic [CNT_W-1:0]    mul_count,
    output logic [CNT_W-1:0]    bch_count,
    output logic                stall,
    output logic [15:0]         stall_cycles,
    output logic                err_flag
);

    localparam logic ST_RUN   = 1'b0;
    localparam logic ST_FLUSH = 1'b1;
    localparam int   FC_W     = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    logic             state;
    logic [FC_W-1:0]  flush_cnt;
    logic [CNT_W-1:0] rs_cnt [3];
    logic [1:0]       cls;
    logic [CNT_W-1:0] cls_count;
    logic             fire;
    logic             in_run;
    logic             commit_ok;
    logic             commit_err;
    logic [2:0]       rel_ok;
    logic [2:0]       rel_err;
    logic [2:0]       fire_cls;

    // Opcode space: 0-7 add, 8-11 mul, 12-15 branch.
    always_comb begin
        cls = 2'd0;
        if (iss_func[3]) begin
            cls = iss_func[2] ? 2'd2 : 2'd1;
        end
    end

    always_comb begin
        cls_count = rs_cnt[0];
        case (cls)
            2'd1:    cls_count = rs_cnt[1];
            2'd2:    cls_count = rs_cnt[2];
            default: cls_count = rs_cnt[0];
        endcase
    end

    assign rob_full      = (rob_count == (ROB_AW+1)'(ROB_DEPTH));
    assign rob_empty     = (rob_count == '0);
    assign iss_ready     = (state == ST_RUN) & ~flush & ~rob_full &
                           (cls_count < CNT_W'(RS_PER_CLS));
    assign fire          = iss_valid & iss_ready;
    assign stall         = iss_valid & ~iss_ready;
    assign alloc_rob_idx = rob_tail;
    assign alloc_class   = cls;
    assign add_count     = rs_cnt[0];
    assign mul_count     = rs_cnt[1];
    assign bch_count     = rs_cnt[2];

    // Commit and release only count (or flag errors) in RUN with no flush pending.
    assign in_run     = (state == ST_RUN) & ~flush;
    assign commit_ok  = in_run & commit_valid & ~rob_empty;
    assign commit_err = in_run & commit_valid & rob_empty;

    always_comb begin
        rel_ok   = '0;
        rel_err  = '0;
        fire_cls = '0;
        for (int i = 0; i < 3; i++) begin
            rel_ok[i]   = in_run & rs_release[i] & (rs_cnt[i] != '0);
            rel_err[i]  = in_run & rs_release[i] & (rs_cnt[i] == '0);
            fire_cls[i] = fire & (cls == 2'(i));
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            flush_cnt <= '0;
        end else if (flush) begin
            state     <= ST_FLUSH;
            flush_cnt <= '0;
        end else if (state == ST_FLUSH) begin
            if (flush_cnt == FC_W'(FLUSH_CYC - 1)) begin
                state     <= ST_RUN;
                flush_cnt <= '0;
            end else begin
                flush_cnt <= flush_cnt + FC_W'(1);
            end
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rob_head  <= '0;
            rob_tail  <= '0;
            rob_count <= '0;
            for (int i = 0; i < 3; i++) begin
                rs_cnt[i] <= '0;
            end
        end else if (flush) begin
            rob_head  <= '0;
            rob_tail  <= '0;
            rob_count <= '0;
            for (int i = 0; i < 3; i++) begin
                rs_cnt[i] <= '0;
            end
        end else begin
            if (fire) begin
                rob_tail <= rob_tail + ROB_AW'(1);
            end
            if (commit_ok) begin
                rob_head <= rob_head + ROB_AW'(1);
            end
            rob_count <= rob_count + (ROB_AW+1)'(fire) - (ROB_AW+1)'(commit_ok);
            for (int i = 0; i < 3; i++) begin
                rs_cnt[i] <= rs_cnt[i] + CNT_W'(fire_cls[i]) - CNT_W'(rel_ok[i]);
            end
        end
    end

    // Error flag and stall counter survive flush; only reset clears them.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            err_flag     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (commit_err | (|rel_err)) begin
                err_flag <= 1'b1;
            end
            if (stall && (stall_cycles != 16'hFFFF)) begin
                stall_cycles <= stall_cycles + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_issue_alloc_ctrl.sv
// Self-checking bench for issue_alloc_ctrl: scoreboard of expected allocations
// plus directed checks of occupancy, wrap, simultaneous events, flush and reset.
module tb_issue_alloc_ctrl;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        iss_valid;
    logic [3:0]  iss_func;
    logic        iss_ready;
    logic [2:0]  alloc_rob_idx;
    logic [1:0]  alloc_class;
    logic [2:0]  rs_release;
    logic        commit_valid;
    logic        flush;
    logic [2:0]  rob_head;
    logic [2:0]  rob_tail;
    logic [3:0]  rob_count;
    logic        rob_full;
    logic        rob_empty;
    logic [1:0]  add_count;
    logic [1:0]  mul_count;
    logic [1:0]  bch_count;
    logic        stall;
    logic [15:0] stall_cycles;
    logic        err_flag;

    typedef struct packed {
        logic [2:0] idx;
        logic [1:0] cls;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e;
    logic [2:0] tail_m;
    int         checks   = 0;
    int         failures = 0;

    issue_alloc_ctrl dut (
        .clk1          (clk1),
        .rst_n         (rst_n),
        .iss_valid     (iss_valid),
        .iss_func      (iss_func),
        .iss_ready     (iss_ready),
        .alloc_rob_idx (alloc_rob_idx),
        .alloc_class   (alloc_class),
        .rs_release    (rs_release),
        .commit_valid  (commit_valid),
        .flush         (flush),
        .rob_head      (rob_head),
        .rob_tail      (rob_tail),
        .rob_count     (rob_count),
        .rob_full      (rob_full),
        .rob_empty     (rob_empty),
        .add_count     (add_count),
        .mul_count     (mul_count),
        .bch_count     (bch_count),
        .stall         (stall),
        .stall_cycles  (stall_cycles),
        .err_flag      (err_flag)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [1:0] func_class(input logic [3:0] f);
        if (f < 4'd8)  return 2'd0;
        if (f < 4'd12) return 2'd1;
        return 2'd2;
    endfunction

    task automatic push_exp(input logic [3:0] f);
        exp_t n;
        n.idx = tail_m;
        n.cls = func_class(f);
        exp_q.push_back(n);
    endtask

    task automatic tick();
        @(posedge clk1);
        @(negedge clk1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iss_valid = 1'b0; iss_func = 4'd0;
        rs_release = 3'b000; commit_valid = 1'b0; flush = 1'b0;
        tail_m = 3'd0;
        #3;
        checks++;
        if ({rob_empty, rob_full, rob_count, rob_head, rob_tail} !== {1'b1, 1'b0, 4'd0, 3'd0, 3'd0}) begin
            failures++;
            $display("[TB] FAIL reset_rob: got empty=%0b full=%0b cnt=%0d h=%0d t=%0d expected 1 0 0 0 0",
                     rob_empty, rob_full, rob_count, rob_head, rob_tail);
        end
        checks++;
        if ({add_count, mul_count, bch_count, err_flag, stall_cycles} !== 23'd0) begin
            failures++;
            $display("[TB] FAIL reset_counts: got add=%0d mul=%0d bch=%0d err=%0b stalls=%0d expected all 0",
                     add_count, mul_count, bch_count, err_flag, stall_cycles);
        end
        @(negedge clk1);
        rst_n = 1'b1;
        iss_valid = 1'b1;
        #1;
        checks++;
        if (iss_ready !== 1'b1 || alloc_rob_idx !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_ready: got ready=%0b idx=%0d expected 1 0", iss_ready, alloc_rob_idx);
        end
        iss_valid = 1'b0;
        @(negedge clk1);
    endtask

    task automatic test_add_stall();
        for (int f = 0; f < 3; f++) begin
            iss_valid = 1'b1;
            iss_func  = 4'(f);
            push_exp(iss_func);
            #1;
            checks++;
            e = exp_q.pop_front();
            if (iss_ready !== 1'b1 || {alloc_rob_idx, alloc_class} !== {e.idx, e.cls}) begin
                failures++;
                $display("[TB] FAIL add_issue%0d: got ready=%0b idx=%0d cls=%0d expected 1 %0d %0d",
                         f, iss_ready, alloc_rob_idx, alloc_class, e.idx, e.cls);
            end
            tick();
            tail_m++;
        end
        iss_func = 4'd3;
        push_exp(iss_func);
        rs_release = 3'b001;
        #1;
        checks++;
        if (iss_ready !== 1'b0 || stall !== 1'b1 || add_count !== 2'd3) begin
            failures++;
            $display("[TB] FAIL add_full_stall: got ready=%0b stall=%0b add=%0d expected 0 1 3",
                     iss_ready, stall, add_count);
        end
        tick();
        rs_release = 3'b000;
        #1;
        checks++;
        e = exp_q.pop_front();
        if (iss_ready !== 1'b1 || {alloc_rob_idx, alloc_class} !== {e.idx, e.cls}) begin
            failures++;
            $display("[TB] FAIL add_after_release: got ready=%0b idx=%0d cls=%0d expected 1 %0d %0d",
                     iss_ready, alloc_rob_idx, alloc_class, e.idx, e.cls);
        end
        tick();
        tail_m++;
        iss_valid = 1'b0;
        checks++;
        if (add_count !== 2'd3 || rob_count !== 4'd4) begin
            failures++;
            $display("[TB] FAIL add_occupancy: got add=%0d cnt=%0d expected 3 4", add_count, rob_count);
        end
    endtask

    task automatic test_fill_wrap();
        logic [3:0] funcs [4];
        logic [2:0] rels  [4];
        funcs = '{4'd8, 4'd12, 4'd9, 4'd1};
        rels  = '{3'b000, 3'b001, 3'b010, 3'b000};
        for (int i = 0; i < 4; i++) begin
            iss_valid  = 1'b1;
            iss_func   = funcs[i];
            rs_release = rels[i];
            push_exp(iss_func);
            #1;
            checks++;
            e = exp_q.pop_front();
            if (iss_ready !== 1'b1 || {alloc_rob_idx, alloc_class} !== {e.idx, e.cls}) begin
                failures++;
                $display("[TB] FAIL fill_issue%0d: got ready=%0b idx=%0d cls=%0d expected 1 %0d %0d",
                         i, iss_ready, alloc_rob_idx, alloc_class, e.idx, e.cls);
            end
            tick();
            tail_m++;
        end
        rs_release = 3'b000;
        iss_func   = 4'd13;
        push_exp(iss_func);
        #1;
        checks++;
        if ({rob_full, rob_count, rob_tail, iss_ready} !== {1'b1, 4'd8, 3'd0, 1'b0}) begin
            failures++;
            $display("[TB] FAIL rob_full: got full=%0b cnt=%0d tail=%0d ready=%0b expected 1 8 0 0",
                     rob_full, rob_count, rob_tail, iss_ready);
        end
        checks++;
        if ({add_count, mul_count, bch_count} !== {2'd3, 2'd1, 2'd1}) begin
            failures++;
            $display("[TB] FAIL fill_classes: got add=%0d mul=%0d bch=%0d expected 3 1 1",
                     add_count, mul_count, bch_count);
        end
        tick();
        iss_valid    = 1'b0;
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        checks++;
        if (rob_head !== 3'd1 || rob_count !== 4'd7 || rob_full !== 1'b0) begin
            failures++;
            $display("[TB] FAIL commit_one: got head=%0d cnt=%0d full=%0b expected 1 7 0",
                     rob_head, rob_count, rob_full);
        end
        iss_valid = 1'b1;
        #1;
        checks++;
        e = exp_q.pop_front();
        if (iss_ready !== 1'b1 || {alloc_rob_idx, alloc_class} !== {e.idx, e.cls}) begin
            failures++;
            $display("[TB] FAIL wrap_issue: got ready=%0b idx=%0d cls=%0d expected 1 %0d %0d",
                     iss_ready, alloc_rob_idx, alloc_class, e.idx, e.cls);
        end
        tick();
        tail_m++;
        iss_valid = 1'b0;
        checks++;
        if (rob_count !== 4'd8 || rob_tail !== 3'd1 || bch_count !== 2'd2) begin
            failures++;
            $display("[TB] FAIL wrap_state: got cnt=%0d tail=%0d bch=%0d expected 8 1 2",
                     rob_count, rob_tail, bch_count);
        end
    endtask

    task automatic test_back_to_back();
        commit_valid = 1'b1;
        tick();
        iss_valid  = 1'b1;
        iss_func   = 4'd10;
        rs_release = 3'b010;
        push_exp(iss_func);
        #1;
        checks++;
        e = exp_q.pop_front();
        if (iss_ready !== 1'b1 || {alloc_rob_idx, alloc_class} !== {e.idx, e.cls}) begin
            failures++;
            $display("[TB] FAIL simul_issue: got ready=%0b idx=%0d cls=%0d expected 1 %0d %0d",
                     iss_ready, alloc_rob_idx, alloc_class, e.idx, e.cls);
        end
        tick();
        tail_m++;
        iss_valid = 1'b0; commit_valid = 1'b0; rs_release = 3'b000;
        checks++;
        if ({rob_count, mul_count, rob_head, rob_tail, err_flag} !== {4'd7, 2'd1, 3'd3, 3'd2, 1'b0}) begin
            failures++;
            $display("[TB] FAIL simul_state: got cnt=%0d mul=%0d h=%0d t=%0d err=%0b expected 7 1 3 2 0",
                     rob_count, mul_count, rob_head, rob_tail, err_flag);
        end
    endtask

    task automatic test_flush();
        commit_valid = 1'b1;
        tick();
        tick();
        commit_valid = 1'b0;
        checks++;
        if (rob_count !== 4'd5 || rob_head !== 3'd5) begin
            failures++;
            $display("[TB] FAIL pre_flush: got cnt=%0d head=%0d expected 5 5", rob_count, rob_head);
        end
        flush = 1'b1; iss_valid = 1'b1; iss_func = 4'd12;
        commit_valid = 1'b1; rs_release = 3'b111;
        #1;
        checks++;
        if (iss_ready !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_blocks: got ready=%0b expected 0", iss_ready);
        end
        tick();
        flush = 1'b0; rs_release = 3'b000;
        tail_m = 3'd0;
        checks++;
        if ({rob_count, rob_head, rob_tail, add_count, mul_count, bch_count} !== 16'd0) begin
            failures++;
            $display("[TB] FAIL flush_clear: got cnt=%0d h=%0d t=%0d add=%0d mul=%0d bch=%0d expected all 0",
                     rob_count, rob_head, rob_tail, add_count, mul_count, bch_count);
        end
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if (iss_ready !== 1'b0) begin
                failures++;
                $display("[TB] FAIL flush_hold%0d: got ready=%0b expected 0", c, iss_ready);
            end
            tick();
        end
        commit_valid = 1'b0;
        push_exp(iss_func);
        #1;
        checks++;
        e = exp_q.pop_front();
        if (iss_ready !== 1'b1 || {alloc_rob_idx, alloc_class} !== {e.idx, e.cls}) begin
            failures++;
            $display("[TB] FAIL flush_resume: got ready=%0b idx=%0d cls=%0d expected 1 %0d %0d",
                     iss_ready, alloc_rob_idx, alloc_class, e.idx, e.cls);
        end
        checks++;
        if (stall_cycles !== 16'd5 || err_flag !== 1'b0) begin
            failures++;
            $display("[TB] FAIL flush_keep: got stalls=%0d err=%0b expected 5 0", stall_cycles, err_flag);
        end
        tick();
        tail_m++;
        iss_valid = 1'b0;
    endtask

    task automatic test_err_stall_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tail_m = 3'd0;
        exp_q.delete();
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        tick();
        checks++;
        if (err_flag !== 1'b1 || rob_count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL err_sticky: got err=%0b cnt=%0d expected 1 0", err_flag, rob_count);
        end
        for (int i = 0; i < 3; i++) begin
            iss_valid = 1'b1;
            iss_func  = 4'(2 * i);
            push_exp(iss_func);
            #1;
            checks++;
            e = exp_q.pop_front();
            if (iss_ready !== 1'b1 || {alloc_rob_idx, alloc_class} !== {e.idx, e.cls}) begin
                failures++;
                $display("[TB] FAIL refill%0d: got ready=%0b idx=%0d cls=%0d expected 1 %0d %0d",
                         i, iss_ready, alloc_rob_idx, alloc_class, e.idx, e.cls);
            end
            tick();
            tail_m++;
        end
        iss_func = 4'd6;
        repeat (5) tick();
        checks++;
        if (stall_cycles !== 16'd5 || add_count !== 2'd3 || err_flag !== 1'b1) begin
            failures++;
            $display("[TB] FAIL stall_count: got stalls=%0d add=%0d err=%0b expected 5 3 1",
                     stall_cycles, add_count, err_flag);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({err_flag, stall_cycles, rob_count, rob_tail, add_count, rob_empty} !== {1'b0, 16'd0, 4'd0, 3'd0, 2'd0, 1'b1}) begin
            failures++;
            $display("[TB] FAIL async_reset: got err=%0b stalls=%0d cnt=%0d t=%0d add=%0d empty=%0b expected 0 0 0 0 0 1",
                     err_flag, stall_cycles, rob_count, rob_tail, add_count, rob_empty);
        end
        iss_valid = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_add_stall();
        test_fill_wrap();
        test_back_to_back();
        test_flush();
        test_err_stall_reset();
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

endmodule
